// File: rtl/shell_thermal_pkg.sv
// rtl/shell_thermal_pkg.sv - shared types and constants for the shell thermal supervisor
package shell_thermal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    EVAL = 2'd3
  } state_t;

  // SYSMON DRP register map (only the die temperature is polled)
  localparam logic [7:0] SYSMON_TEMP_ADDR = 8'h00;

  // Linear fit of the SYSMON transfer function around the 80-110 C region,
  // good enough to derive threshold defaults from degrees C.
  function automatic logic [9:0] degc_to_code(input int degc);
    return 10'((degc * 21) / 10 + 556);
  endfunction

  localparam logic [9:0] DEF_FPGA_TRIP_CODE = degc_to_code(100);
  localparam logic [9:0] DEF_FPGA_WARN_CODE = degc_to_code(90);
  localparam logic [9:0] DEF_WARN_HYST      = 10'd10;
  localparam logic [6:0] DEF_HBM_TRIP_TEMP  = 7'd105;

endpackage

// File: rtl/shell_thermal_supervisor_drp.sv
// rtl/shell_thermal_supervisor_drp.sv - DRP read engine: den pulse, drdy wait window, timeout
module drp_read_engine
  import shell_thermal_pkg::*;
#(
  parameter int         DRP_TIMEOUT = 255,
  parameter logic [7:0] ADDR        = SYSMON_TEMP_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       den,
  output logic       dwe,
  output logic [7:0] daddr,
  input  logic       drdy,
  input  logic [9:0] data,
  output logic       rd_valid,
  output logic       rd_timeout,
  output logic [9:0] rd_code
);

  localparam int TW = (DRP_TIMEOUT < 2) ? 1 : $clog2(DRP_TIMEOUT + 1);

  logic          waiting;
  logic [TW-1:0] timer;

  assign dwe   = 1'b0;
  assign daddr = ADDR;

  // drdy wins over an expiring timer in the same cycle; drdy outside the window is dropped
  assign rd_valid   = waiting & drdy;
  assign rd_timeout = waiting & ~drdy & (timer == TW'(DRP_TIMEOUT - 1));
  assign rd_code    = data;

  // One-cycle den, then a bounded window waiting for drdy
  always_ff @(posedge clk) begin
    if (rst) begin
      den     <= 1'b0;
      waiting <= 1'b0;
      timer   <= '0;
    end else begin
      den <= start & ~den & ~waiting;
      if (den) begin
        waiting <= 1'b1;
        timer   <= '0;
      end else if (rd_valid || rd_timeout) begin
        waiting <= 1'b0;
      end else if (waiting) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shell_thermal_supervisor.sv
// rtl/shell_thermal_supervisor.sv - die/HBM temperature polling, trip, warn and sensor-fault flags
module shell_thermal_supervisor
  import shell_thermal_pkg::*;
#(
  parameter int         POLL_CYCLES    = 100000,
  parameter int         DRP_TIMEOUT    = 255,
  parameter int         FAULT_LIMIT    = 3,
  parameter logic [7:0] TEMP_ADDR      = SYSMON_TEMP_ADDR,
  parameter logic [9:0] FPGA_TRIP_CODE = DEF_FPGA_TRIP_CODE,
  parameter logic [9:0] FPGA_WARN_CODE = DEF_FPGA_WARN_CODE,
  parameter logic [9:0] WARN_HYST      = DEF_WARN_HYST,
  parameter logic [6:0] HBM_TRIP_TEMP  = DEF_HBM_TRIP_TEMP
) (
  input  logic        shell_clk,
  input  logic        shell_rst,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [7:0]  drp_daddr,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  input  logic [1:0]  hbm_stat_cattrip,
  input  logic [13:0] hbm_stat_temp,
  output logic        hbm_cattrip,
  output logic        temp_warn,
  output logic        sensor_fault,
  output logic [9:0]  fpga_temp_code,
  output logic [6:0]  hbm_temp_max,
  output logic        sample_valid
);

  localparam int         PW            = $clog2(POLL_CYCLES);
  localparam logic [9:0] WARN_CLR_CODE = FPGA_WARN_CODE - WARN_HYST;

  if (WARN_HYST > FPGA_WARN_CODE) begin : g_hyst_check
    $error("WARN_HYST must not exceed FPGA_WARN_CODE");
  end
  if (POLL_CYCLES < 8) begin : g_poll_check
    $error("POLL_CYCLES must be at least 8");
  end

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [7:0]    tcount;

  logic          start;
  logic          rd_valid;
  logic          rd_timeout;
  logic [9:0]    rd_code;

  logic [1:0]    cat_q;
  logic          hot_q;
  logic          hbm_trip;
  logic          fpga_trip;
  logic          trip_now;
  logic          warn_eval;
  logic          unused_drp_bits;

  assign unused_drp_bits = ^drp_do[5:0];

  // Request issued on the last IDLE cycle so den lands in the REQ cycle
  assign start = (state == IDLE) && (poll_cnt == '0);

  drp_read_engine #(
    .DRP_TIMEOUT (DRP_TIMEOUT),
    .ADDR        (TEMP_ADDR)
  ) u_drp (
    .clk        (shell_clk),
    .rst        (shell_rst),
    .start      (start),
    .den        (drp_den),
    .dwe        (drp_dwe),
    .daddr      (drp_daddr),
    .drdy       (drp_drdy),
    .data       (drp_do[15:6]),
    .rd_valid   (rd_valid),
    .rd_timeout (rd_timeout),
    .rd_code    (rd_code)
  );

  // Trip and warn decisions for the current cycle
  always_comb begin
    hbm_trip  = (|(hbm_stat_cattrip & cat_q)) | (hot_q & (hbm_temp_max >= HBM_TRIP_TEMP));
    fpga_trip = rd_valid & (rd_code >= FPGA_TRIP_CODE);
    trip_now  = hbm_trip | fpga_trip;
    warn_eval = temp_warn;
    if (rd_code >= FPGA_WARN_CODE) begin
      warn_eval = 1'b1;
    end else if (rd_code < WARN_CLR_CODE) begin
      warn_eval = 1'b0;
    end
  end

  // HBM cattrip glitch filter and two-cycle over-temperature qualification
  always_ff @(posedge shell_clk) begin
    if (shell_rst) begin
      cat_q        <= '0;
      hot_q        <= 1'b0;
      hbm_temp_max <= '0;
    end else begin
      cat_q        <= hbm_stat_cattrip;
      hbm_temp_max <= (hbm_stat_temp[13:7] > hbm_stat_temp[6:0]) ? hbm_stat_temp[13:7]
                                                                  : hbm_stat_temp[6:0];
      hot_q        <= hbm_temp_max >= HBM_TRIP_TEMP;
    end
  end

  // Poll sequencer with registered status outputs
  always_ff @(posedge shell_clk) begin
    if (shell_rst) begin
      state          <= IDLE;
      poll_cnt       <= PW'(POLL_CYCLES - 1);
      tcount         <= '0;
      sensor_fault   <= 1'b0;
      fpga_temp_code <= '0;
      sample_valid   <= 1'b0;
      hbm_cattrip    <= 1'b0;
      temp_warn      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      hbm_cattrip  <= hbm_cattrip | trip_now;
      temp_warn    <= hbm_cattrip | trip_now | (rd_valid ? warn_eval : temp_warn);
      case (state)
        IDLE: begin
          if (poll_cnt == '0) begin
            state <= REQ;
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
        end
        WAIT: begin
          if (rd_valid) begin
            fpga_temp_code <= rd_code;
            sample_valid   <= 1'b1;
            tcount         <= '0;
            state          <= EVAL;
          end else if (rd_timeout) begin
            if (tcount < 8'(FAULT_LIMIT)) begin
              tcount <= tcount + 8'd1;
            end
            if (tcount + 8'd1 >= 8'(FAULT_LIMIT)) begin
              sensor_fault <= 1'b1;
            end
            poll_cnt <= PW'(POLL_CYCLES - 1);
            state    <= IDLE;
          end
        end
        EVAL: begin
          poll_cnt <= PW'(POLL_CYCLES - 1);
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shell_thermal_supervisor.sv
// tb/tb_shell_thermal_supervisor.sv - self-checking bench for shell_thermal_supervisor
module tb_shell_thermal_supervisor;

  localparam int POLL = 16;

  logic        shell_clk = 1'b0;
  logic        shell_rst;
  logic        drp_den;
  logic        drp_dwe;
  logic [7:0]  drp_daddr;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [1:0]  hbm_stat_cattrip;
  logic [13:0] hbm_stat_temp;
  logic        hbm_cattrip;
  logic        temp_warn;
  logic        sensor_fault;
  logic [9:0]  fpga_temp_code;
  logic [6:0]  hbm_temp_max;
  logic        sample_valid;

  typedef struct {
    logic [9:0] code;
    logic       warn;
    logic       cat;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[10];
  vec_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_den = 0;

  shell_thermal_supervisor #(
    .POLL_CYCLES (POLL),
    .DRP_TIMEOUT (8),
    .FAULT_LIMIT (3)
  ) dut (
    .shell_clk        (shell_clk),
    .shell_rst        (shell_rst),
    .drp_den          (drp_den),
    .drp_dwe          (drp_dwe),
    .drp_daddr        (drp_daddr),
    .drp_drdy         (drp_drdy),
    .drp_do           (drp_do),
    .hbm_stat_cattrip (hbm_stat_cattrip),
    .hbm_stat_temp    (hbm_stat_temp),
    .hbm_cattrip      (hbm_cattrip),
    .temp_warn        (temp_warn),
    .sensor_fault     (sensor_fault),
    .fpga_temp_code   (fpga_temp_code),
    .hbm_temp_max     (hbm_temp_max),
    .sample_valid     (sample_valid)
  );

  always #5 shell_clk = ~shell_clk;

  always @(posedge shell_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every sample_valid must match the oldest pushed expectation
  always @(negedge shell_clk) begin
    if (sample_valid === 1'b1) begin
      check("sample_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("temp_code", 32'(fpga_temp_code), 32'(mon_e.code));
        check("temp_warn", 32'(temp_warn), 32'(mon_e.warn));
        check("hbm_cattrip", 32'(hbm_cattrip), 32'(mon_e.cat));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_den", 32'(drp_den), 0);
    check("rst_dwe", 32'(drp_dwe), 0);
    check("rst_daddr", 32'(drp_daddr), 0);
    check("rst_cattrip", 32'(hbm_cattrip), 0);
    check("rst_warn", 32'(temp_warn), 0);
    check("rst_fault", 32'(sensor_fault), 0);
    check("rst_code", 32'(fpga_temp_code), 0);
    check("rst_tmax", 32'(hbm_temp_max), 0);
    check("rst_sample", 32'(sample_valid), 0);
    check("rst_queue_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic apply_reset();
    @(negedge shell_clk);
    shell_rst = 1'b1;
    drp_drdy = 1'b0;
    hbm_stat_cattrip = 2'b00;
    hbm_stat_temp = '0;
    @(negedge shell_clk);
    @(negedge shell_clk);
    check_reset_outputs();
    shell_rst = 1'b0;
  endtask

  task automatic wait_den(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge shell_clk);
      if (drp_den === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("den_seen", 32'(ok), 1);
  endtask

  // Respond to the next den three cycles later with the given code
  task automatic drp_read(input vec_t v, input bit check_period);
    bit ok;
    wait_den(ok);
    if (ok) begin
      if (check_period) check("den_period", 32'(cyc - last_den), POLL + 5);
      last_den = cyc;
      @(negedge shell_clk);
      check("den_one_cycle", 32'(drp_den), 0);
      @(negedge shell_clk);
      @(negedge shell_clk);
      drp_drdy = 1'b1;
      drp_do = {v.code, 6'($urandom)};
      exp_q.push_back(v);
      @(negedge shell_clk);
      drp_drdy = 1'b0;
      drp_do = 16'($urandom);
      check("sample_latency", 32'(sample_valid), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit sv_seen;
    int nd;
    int n;

    vecs[0] = '{10'h2D0, 1'b0, 1'b0};
    vecs[1] = '{10'h2EA, 1'b1, 1'b0};
    vecs[2] = '{10'h2E0, 1'b1, 1'b0};
    vecs[3] = '{10'h2DE, 1'b0, 1'b0};
    vecs[4] = '{10'h2E9, 1'b1, 1'b0};
    vecs[5] = '{10'h2DF, 1'b1, 1'b0};
    vecs[6] = '{10'h2DE, 1'b0, 1'b0};
    vecs[7] = '{10'h2FD, 1'b1, 1'b0};
    vecs[8] = '{10'h2FE, 1'b1, 1'b1};
    vecs[9] = '{10'h200, 1'b1, 1'b1};

    shell_rst = 1'b1;
    drp_drdy = 1'b0;
    drp_do = '0;
    hbm_stat_cattrip = 2'b00;
    hbm_stat_temp = '0;
    repeat (3) @(negedge shell_clk);
    check_reset_outputs();
    shell_rst = 1'b0;

    // Table of die readings: warn hysteresis, trip boundary, sticky trip
    for (int i = 0; i < 10; i++) drp_read(vecs[i], i > 0);
    repeat (5) @(negedge shell_clk);
    check("cattrip_sticky", 32'(hbm_cattrip), 1);
    check("last_code", 32'(fpga_temp_code), 32'h200);

    // HBM cattrip glitch filter
    apply_reset();
    @(negedge shell_clk) hbm_stat_cattrip = 2'b10;
    @(negedge shell_clk) hbm_stat_cattrip = 2'b00;
    repeat (4) @(negedge shell_clk);
    check("cattrip_glitch", 32'(hbm_cattrip), 0);
    @(negedge shell_clk) hbm_stat_cattrip = 2'b10;
    @(negedge shell_clk);
    @(negedge shell_clk);
    check("cattrip_filtered", 32'(hbm_cattrip), 1);
    check("warn_forced", 32'(temp_warn), 1);
    hbm_stat_cattrip = 2'b00;

    // HBM over-temperature
    apply_reset();
    @(negedge shell_clk) hbm_stat_temp = {7'd105, 7'd0};
    @(negedge shell_clk);
    check("tmax_stack1", 32'(hbm_temp_max), 105);
    hbm_stat_temp = '0;
    repeat (4) @(negedge shell_clk);
    check("hot_one_cycle", 32'(hbm_cattrip), 0);
    @(negedge shell_clk) hbm_stat_temp = {7'd3, 7'd104};
    repeat (3) @(negedge shell_clk);
    check("tmax_stack0", 32'(hbm_temp_max), 104);
    check("hot_below", 32'(hbm_cattrip), 0);
    hbm_stat_temp = '0;
    repeat (2) @(negedge shell_clk);
    hbm_stat_temp = {7'd105, 7'd0};
    @(negedge shell_clk);
    @(negedge shell_clk);
    hbm_stat_temp = '0;
    check("hot_not_yet", 32'(hbm_cattrip), 0);
    @(negedge shell_clk);
    check("hot_trip", 32'(hbm_cattrip), 1);

    // DRP never answers: fault after the third timeout, then reads resume
    apply_reset();
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge shell_clk);
      if (drp_den === 1'b1) nd++;
      if (sensor_fault === 1'b1) break;
    end
    check("fault_set", 32'(sensor_fault), 1);
    check("fault_den_count", 32'(nd), 3);
    drp_read('{10'h2D0, 1'b0, 1'b0}, 1'b0);
    drp_read('{10'h2EA, 1'b1, 1'b0}, 1'b1);
    check("fault_sticky", 32'(sensor_fault), 1);

    // Reset during WAIT, late drdy must be ignored
    wait_den(ok);
    @(negedge shell_clk);
    @(negedge shell_clk);
    shell_rst = 1'b1;
    @(negedge shell_clk);
    shell_rst = 1'b0;
    drp_drdy = 1'b1;
    drp_do = {10'h2FE, 6'h0};
    n = 0;
    sv_seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge shell_clk);
      if (i == 1) drp_drdy = 1'b0;
      if (sample_valid === 1'b1) sv_seen = 1'b1;
      if (drp_den === 1'b1) begin
        n = i;
        break;
      end
    end
    check("midread_no_sample", 32'(sv_seen), 0);
    check("midread_den_delay", 32'(n), POLL);
    check("midread_code", 32'(fpga_temp_code), 0);
    check("midread_cattrip", 32'(hbm_cattrip), 0);
    check("midread_warn", 32'(temp_warn), 0);
    check("midread_fault", 32'(sensor_fault), 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
